// File: rtl/scalar_load_pkg.sv
// Shared constants for the scalar-unit tensor load sequencer.
// FSM encodings, loader target indices and counter sizing.
package scalar_load_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam int unsigned TGT_BIAS  = 0;
    localparam int unsigned TGT_SCALE = 1;
    localparam int unsigned TGT_RELU  = 2;

    localparam int unsigned DefaultLaneDepth = 4;
    localparam int unsigned CntWidth         = $clog2(DefaultLaneDepth + 1);

    // Counters must hold the value lane_depth itself, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/scalar_load_addr_gen.sv
// Request address generator: latches the tensor base and counts issued requests.
// Addresses wrap modulo 2^addr_width_p.
module scalar_load_addr_gen
    import scalar_load_pkg::*;
#(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned lane_depth_p = 4,
    parameter int unsigned stride_p     = 8,
    parameter int unsigned cnt_width_p  = cnt_width(lane_depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [addr_width_p-1:0] base_i,
    input  logic                    advance_i,
    output logic [addr_width_p-1:0] addr_o,
    output logic [cnt_width_p-1:0]  req_cnt_o,
    output logic                    last_o
);

    logic [addr_width_p-1:0] base_q, base_d;
    logic [cnt_width_p-1:0]  req_cnt_q, req_cnt_d;

    always_comb begin
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        if (load_i) begin
            base_d    = base_i;
            req_cnt_d = '0;
        end else if (advance_i) begin
            req_cnt_d = req_cnt_q + cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_q    <= '0;
            req_cnt_q <= '0;
        end else begin
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
        end
    end

    assign addr_o    = base_q + addr_width_p'(req_cnt_q) * addr_width_p'(stride_p);
    assign req_cnt_o = req_cnt_q;
    assign last_o    = (req_cnt_q == cnt_width_p'(lane_depth_p - 1));

endmodule

// File: rtl/scalar_load_ctrl.sv
// Sequences a fixed-length tensor load from memory into one scalar unit's shift loader,
// issuing one read per beat and gating in-order responses to the selected loader.
module scalar_load_ctrl
    import scalar_load_pkg::*;
#(
    parameter int unsigned addr_width_p     = 32,
    parameter int unsigned read_bus_width_p = 64,
    parameter int unsigned lane_depth_p     = 4,
    parameter int unsigned num_targets_p    = 3,
    parameter int unsigned stride_p         = read_bus_width_p / 8
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [addr_width_p-1:0]          cmd_addr_i,
    input  logic [$clog2(num_targets_p)-1:0] cmd_target_i,
    input  logic                             pipe_busy_i,
    output logic                             rd_req_valid_o,
    input  logic                             rd_req_ready_i,
    output logic [addr_width_p-1:0]          rd_addr_o,
    input  logic                             rd_resp_valid_i,
    output logic                             load_valid_o,
    output logic [num_targets_p-1:0]         load_enable_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int unsigned CntW = cnt_width(lane_depth_p);
    localparam int unsigned TgtW = $clog2(num_targets_p);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] resp_cnt_q, resp_cnt_d;
    logic [TgtW-1:0] target_q, target_d;

    logic                     cmd_accept;
    logic                     req_hs;
    logic                     req_last;
    logic                     resp_accept;
    logic                     resp_last;
    logic [CntW-1:0]          req_cnt;
    logic [num_targets_p-1:0] target_onehot;

    scalar_load_addr_gen #(
        .addr_width_p (addr_width_p),
        .lane_depth_p (lane_depth_p),
        .stride_p     (stride_p),
        .cnt_width_p  (CntW)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (cmd_accept),
        .base_i    (cmd_addr_i),
        .advance_i (req_hs),
        .addr_o    (rd_addr_o),
        .req_cnt_o (req_cnt),
        .last_o    (req_last)
    );

    assign cmd_accept = (state_q == StIdle) && cmd_valid_i && !pipe_busy_i;
    assign req_hs     = (state_q == StReq) && rd_req_ready_i;

    // req_cnt is the pre-edge value, so a beat returning in its own request cycle is rejected.
    assign resp_accept = ((state_q == StReq) || (state_q == StDrain)) && rd_resp_valid_i &&
                         (resp_cnt_q < req_cnt);
    assign resp_last   = resp_accept && (resp_cnt_q == CntW'(lane_depth_p - 1));

    // Out-of-range targets decode to all-zero so the load runs without touching any loader.
    always_comb begin
        target_onehot = '0;
        for (int unsigned i = 0; i < num_targets_p; i++) begin
            target_onehot[i] = (32'(target_q) == i);
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_cnt_d = resp_cnt_q;
        target_d   = target_q;
        if (cmd_accept) begin
            resp_cnt_d = '0;
            target_d   = cmd_target_i;
        end else if (resp_accept) begin
            resp_cnt_d = resp_cnt_q + CntW'(1);
        end
        unique case (state_q)
            StIdle:  if (cmd_accept) state_d = StReq;
            StReq: begin
                if (resp_last) begin
                    state_d = StDone;
                end else if (req_hs && req_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (resp_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            resp_cnt_q <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            resp_cnt_q <= resp_cnt_d;
            target_q   <= target_d;
        end
    end

    assign cmd_ready_o    = (state_q == StIdle) && !pipe_busy_i;
    assign rd_req_valid_o = (state_q == StReq);
    assign load_valid_o   = resp_accept;
    assign load_enable_o  = resp_accept ? target_onehot : '0;
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);

endmodule

// File: tb/tb_scalar_load_ctrl.sv
// Bench for scalar_load_ctrl: table of loads plus hand-written corner sequences,
// with address/enable/done scoreboards and a latency-programmable memory model.
module tb_scalar_load_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [1:0]  cmd_target_i = '0;
    logic        pipe_busy_i = 1'b0;
    logic        rd_req_ready_i = 1'b1;
    logic        rd_resp_valid_i = 1'b0;

    logic        cmd_ready_o, rd_req_valid_o, load_valid_o, busy_o, done_o;
    logic [31:0] rd_addr_o;
    logic [2:0]  load_enable_o;

    logic        n_cmd_ready_o, n_rd_req_valid_o, n_load_valid_o, n_busy_o, n_done_o;
    logic [7:0]  n_rd_addr_o;
    logic [2:0]  n_load_enable_o;

    scalar_load_ctrl dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_addr_i      (cmd_addr_i),
        .cmd_target_i    (cmd_target_i),
        .pipe_busy_i     (pipe_busy_i),
        .rd_req_valid_o  (rd_req_valid_o),
        .rd_req_ready_i  (rd_req_ready_i),
        .rd_addr_o       (rd_addr_o),
        .rd_resp_valid_i (rd_resp_valid_i),
        .load_valid_o    (load_valid_o),
        .load_enable_o   (load_enable_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    // Narrow-address copy driven in lockstep; only its addresses are scored.
    scalar_load_ctrl #(.addr_width_p(8)) dut_narrow (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (n_cmd_ready_o),
        .cmd_addr_i      (cmd_addr_i[7:0]),
        .cmd_target_i    (cmd_target_i),
        .pipe_busy_i     (pipe_busy_i),
        .rd_req_valid_o  (n_rd_req_valid_o),
        .rd_req_ready_i  (rd_req_ready_i),
        .rd_addr_o       (n_rd_addr_o),
        .rd_resp_valid_i (rd_resp_valid_i),
        .load_valid_o    (n_load_valid_o),
        .load_enable_o   (n_load_enable_o),
        .busy_o          (n_busy_o),
        .done_o          (n_done_o)
    );

    typedef struct {
        logic [31:0] base;
        logic [1:0]  tgt;
        logic [3:0]  ready_pat;
        int          lat;
        logic [2:0]  exp_en;
    } vec_t;

    vec_t        vecs[4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] addr_q[$];
    logic [2:0]  en_q[$];
    int          resp_due[$];
    int          done_pending = 0;
    int          lat = 2;
    logic [3:0]  ready_pat = 4'b1111;
    int          spur = 0;
    bit          spur_after_last = 1'b0;
    bit          accepted = 1'b0;
    logic [2:0]  pend_en = '0;
    int          beats_seen = 0;
    int          last_beat_cyc = 0;
    int          waited;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mid-cycle monitor: scores requests, beats and done pulses against the queues.
    task automatic mid();
        #4;
        accepted = 1'b0;
        if (rd_req_valid_o) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_req", rd_req_valid_o, 0);
            end else begin
                chk("rd_addr", rd_addr_o, addr_q[0]);
                chk("rd_addr_narrow", n_rd_addr_o, addr_q[0][7:0]);
                if (rd_req_ready_i) begin
                    void'(addr_q.pop_front());
                    resp_due.push_back(cyc + lat);
                end
            end
        end
        if (load_valid_o) begin
            beats_seen++;
            last_beat_cyc = cyc;
            if (en_q.size() == 0) begin
                chk("spurious_load_valid", load_valid_o, 0);
            end else begin
                chk("load_enable", load_enable_o, en_q.pop_front());
                if (en_q.size() == 0 && spur_after_last) begin
                    spur = 2;
                    spur_after_last = 1'b0;
                end
            end
        end else begin
            chk("enable_without_valid", load_enable_o, 0);
        end
        if (done_o) begin
            if (done_pending == 0) begin
                chk("extra_done", done_o, 0);
            end else begin
                done_pending--;
                chk("done_latency", cyc - last_beat_cyc, 1);
                chk("busy_during_done", busy_o, 1);
            end
        end
        if (cmd_valid_i && cmd_ready_o) begin
            accepted = 1'b1;
            for (int i = 0; i < 4; i++) begin
                addr_q.push_back(cmd_addr_i + 32'(i * 8));
                en_q.push_back(pend_en);
            end
            done_pending++;
        end
    endtask

    // Advance one edge and drive the memory side for the new cycle.
    task automatic edge_adv();
        @(posedge clk);
        #1;
        cyc++;
        rd_req_ready_i  = ready_pat[cyc % 4];
        rd_resp_valid_i = 1'b0;
        if (resp_due.size() > 0 && resp_due[0] == cyc) begin
            void'(resp_due.pop_front());
            rd_resp_valid_i = 1'b1;
        end
        if (spur > 0) begin
            rd_resp_valid_i = 1'b1;
            spur--;
        end
    endtask

    task automatic cycle();
        mid();
        edge_adv();
    endtask

    task automatic issue(input logic [31:0] base, input logic [1:0] tgt, input logic [2:0] exp_en,
                         output int n);
        cmd_addr_i   = base;
        cmd_target_i = tgt;
        pend_en      = exp_en;
        cmd_valid_i  = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            cycle();
            n++;
        end
        cmd_valid_i = 1'b0;
        chk("cmd_accepted", accepted, 1);
    endtask

    task automatic run_until_done();
        int n = 0;
        while ((done_pending > 0 || addr_q.size() > 0 || en_q.size() > 0) && n < 200) begin
            cycle();
            n++;
        end
        chk("load_completes", done_pending + addr_q.size() + en_q.size(), 0);
        #2;
        chk("busy_after_done", busy_o, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_req_valid"}, rd_req_valid_o, 0);
        chk({tag, "_load_valid"}, load_valid_o, 0);
        chk({tag, "_load_enable"}, load_enable_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 2'd1, 4'b1111, 2, 3'b010};
        vecs[1] = '{32'h0000_0100, 2'd0, 4'b1001, 2, 3'b001};
        vecs[2] = '{32'h0000_00F8, 2'd2, 4'b1111, 1, 3'b100};
        vecs[3] = '{32'hFFFF_FFF0, 2'd3, 4'b1101, 3, 3'b000};

        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        pipe_busy_i = 1'b1;
        #1;
        chk("reset_cmd_ready_pipe_busy", cmd_ready_o, 0);
        pipe_busy_i = 1'b0;
        reset_i = 1'b0;
        cycle();

        for (int v = 0; v < 4; v++) begin
            ready_pat = vecs[v].ready_pat;
            lat       = vecs[v].lat;
            issue(vecs[v].base, vecs[v].tgt, vecs[v].exp_en, waited);
            run_until_done();
            cycle();
        end

        // Pipeline-busy hold-off, then pipe_busy rising mid-load must be ignored.
        ready_pat = 4'b1111;
        lat = 2;
        pipe_busy_i  = 1'b1;
        cmd_valid_i  = 1'b1;
        cmd_addr_i   = 32'h200;
        cmd_target_i = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("holdoff_cmd_ready", cmd_ready_o, 0);
            chk("holdoff_no_req", rd_req_valid_o, 0);
            cycle();
        end
        pipe_busy_i = 1'b0;
        issue(32'h200, 2'd0, 3'b001, waited);
        chk("holdoff_accept_cycles", waited, 1);
        #2;
        chk("holdoff_req_next_cycle", rd_req_valid_o, 1);
        pipe_busy_i = 1'b1;
        run_until_done();
        pipe_busy_i = 1'b0;
        cycle();

        // Spurious responses in IDLE and right after a completed load.
        rd_resp_valid_i = 1'b1;
        spur = 2;
        #2;
        chk("idle_resp_no_valid", load_valid_o, 0);
        chk("idle_resp_no_enable", load_enable_o, 0);
        repeat (3) cycle();
        spur_after_last = 1'b1;
        issue(32'h100, 2'd2, 3'b100, waited);
        run_until_done();
        repeat (3) cycle();

        // Reset after two accepted beats.
        beats_seen = 0;
        issue(32'h300, 2'd1, 3'b010, waited);
        for (int i = 0; i < 50 && beats_seen < 2; i++) cycle();
        chk("two_beats_before_reset", beats_seen, 2);
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        addr_q.delete();
        en_q.delete();
        done_pending = 0;
        #2;
        chk_reset_outputs("midload_reset");
        repeat (4) cycle();
        issue(32'h300, 2'd1, 3'b010, waited);
        run_until_done();
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_load_ctrl.md
Name: scalar_load_ctrl

Overview:
Sequences a tensor load from memory into one of the scalar units (bias adder, scale multiplier, relu). It accepts a load command from the control unit, waits for the scalar pipeline to be idle, and issues one read request per bus beat. It gates each returned beat into the selected unit's shift loader by driving that unit's load_valid/load_enable. It then reports completion, so the control unit never overlaps a load with pipeline use.

Parameters:
addr_width_p, 32, byte-address width of read requests
read_bus_width_p, 64, read data bus width in bits; one request returns one beat
lane_depth_p, 4, beats per load; equals the shift depth of each loader
num_targets_p, 3, number of scalar units with a loader
stride_p, read_bus_width_p/8, byte increment between consecutive request addresses

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  control unit presents a load command
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_addr_i  in  addr_width_p  base byte address of the tensor
cmd_target_i  in  $clog2(num_targets_p)  index of the destination scalar unit
pipe_busy_i  in  1  scalar pipeline in use; no command is accepted while high
rd_req_valid_o  out  1  read request valid
rd_req_ready_i  in  1  memory accepts the request
rd_addr_o  out  addr_width_p  read request byte address
rd_resp_valid_i  in  1  read bus carries a valid beat (in-order responses)
load_valid_o  out  1  to loaders: beat on read bus is valid for this load
load_enable_o  out  num_targets_p  one-hot loader select
busy_o  out  1  load in progress
done_o  out  1  single-cycle pulse when a load completes

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state=IDLE, req_cnt=0, resp_cnt=0, target_q=0, base_q=0.
- Reset values of outputs: rd_req_valid_o=0, load_valid_o=0, load_enable_o=0, busy_o=0, done_o=0. cmd_ready_o follows pipe_busy_i (1 if pipe_busy_i=0).
- Reset asserted mid-load: return to IDLE next edge. No done_o. Outstanding responses arriving afterwards are ignored.
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE:
  - cmd_ready_o = !pipe_busy_i.
  - On accept: latch base_q=cmd_addr_i, target_q=cmd_target_i; clear both counters; go to REQ.
  - cmd_target_i >= num_targets_p: accepted, but load_enable_o stays 0 for that load. The load still completes with done_o.
- REQ:
  - rd_req_valid_o=1; rd_addr_o = base_q + req_cnt*stride_p, truncated modulo 2^addr_width_p (wrap allowed).
  - req_cnt increments on rd_req_valid_o & rd_req_ready_i.
  - When the handshake with req_cnt == lane_depth_p-1 completes, go to DRAIN. If that same cycle's response completes the load, go directly to DONE.
- DRAIN: no requests; wait for resp_cnt to reach lane_depth_p.
- Response gating, in REQ and DRAIN:
  - A beat is accepted when rd_resp_valid_i=1 and resp_cnt < req_cnt.
  - A same-cycle request handshake does not count toward in-flight, so zero-cycle memory responses are not accepted.
  - On accept: load_valid_o=1 and load_enable_o=onehot(target_q), combinationally in the same cycle, with zero latency so the beat shifts in on that edge. resp_cnt then increments.
  - Accepting beat lane_depth_p-1 moves the FSM to DONE.
- Spurious responses are ignored: load_valid_o and load_enable_o stay 0. This covers rd_resp_valid_i in IDLE/DONE and any response with resp_cnt >= req_cnt.
- DONE: done_o=1 for exactly one cycle; cmd_ready_o=0; then IDLE. Back-to-back commands therefore have at least one idle cycle between them.
- busy_o = (state != IDLE).
- pipe_busy_i rising during REQ/DRAIN has no effect; the control unit guarantees exclusion.
- Counters are $clog2(lane_depth_p+1) bits wide; they do not overflow.

Decomposition:
- Package scalar_load_pkg:
  - state enum (IDLE, REQ, DRAIN, DONE)
  - target index constants TGT_BIAS=0, TGT_SCALE=1, TGT_RELU=2
  - localparam for counter width
- One natural sub-module, scalar_load_addr_gen: base register plus request counter producing rd_addr_o and a last-request flag.
- All other logic (FSM, response gating, one-hot decode) lives in scalar_load_ctrl.

Test Plan:
- Basic load: cmd addr=0x100, target=1; rd_req_ready_i=1; responses 2 cycles after each request.
  - rd_addr_o sequence 0x100, 0x108, 0x110, 0x118.
  - load_enable_o=3'b010 with load_valid_o on exactly 4 cycles.
  - done_o pulse one cycle after the 4th beat; busy_o falls with it.
- Pipeline-busy hold-off: pipe_busy_i=1 for 5 cycles with cmd_valid_i=1.
  - cmd_ready_o=0 and no rd_req_valid_o during those cycles.
  - Command accepted the cycle pipe_busy_i drops; REQ the next cycle.
- Request backpressure: rd_req_ready_i toggles 1,0,0,1,...
  - rd_addr_o stable while stalled; exactly 4 request handshakes, addresses 0x100..0x118.
- Spurious responses: rd_resp_valid_i=1 in IDLE, and a 5th beat after DONE.
  - load_valid_o=0 and load_enable_o=0 in both cases; no extra done_o.
- Address wrap: addr_width_p=8, base=0xF8 -> addresses 0xF8, 0x00, 0x08, 0x10.
- Reset mid-load: reset after 2 accepted beats -> all outputs at reset values next cycle; no done_o. A new command then completes a full 4-beat load.
